// File: rtl/cellram_responder_if.sv
// CellRAM synchronous-burst bus between the memory arbitrator (master) and the
// responder (slave). Clock and reset are carried as plain ports, not here.
interface cellram_responder_if;
    logic [22:0] mem_addr;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic        mem_data_oe;
    logic        mem_ce;
    logic        mem_oe;
    logic        mem_we;
    logic        mem_addr_valid;
    logic        mem_cre;
    logic        mem_wait;

    modport master (
        output mem_addr, mem_data_in, mem_ce, mem_oe, mem_we, mem_addr_valid, mem_cre,
        input  mem_data_out, mem_data_oe, mem_wait
    );

    modport slave (
        input  mem_addr, mem_data_in, mem_ce, mem_oe, mem_we, mem_addr_valid, mem_cre,
        output mem_data_out, mem_data_oe, mem_wait
    );
endinterface

// File: rtl/cellram_responder.sv
// CellRAM responder: captures the BCR, applies its latency code and serves
// burst writes/reads from an internal word array, pacing the master with mem_wait.
module cellram_responder #(
    parameter int ADDR_BITS       = 12,
    parameter int DEFAULT_LATENCY = 3,
    parameter int CFG_CYCLES      = 2
) (
    input  logic                clk,
    input  logic                reset,
    cellram_responder_if.slave  bus,
    output logic [22:0]         bcr,
    output logic                config_done
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_LATENCY,
        S_BURST_WR,
        S_BURST_RD
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 dir_q, dir_d;
    logic                 wait_q, wait_d;
    logic [15:0]          rdata_q, rdata_d;
    logic [22:0]          bcr_q, bcr_d;
    logic                 cfg_done_q, cfg_done_d;

    logic [15:0]          mem_q [DEPTH];
    logic [2:0]           lat_code;
    logic [CNT_W-1:0]     lat_m1;
    logic [ADDR_BITS-1:0] addr_inc;
    logic                 wr_en;

    assign lat_code = bcr_q[13:11];
    assign addr_inc = addr_q + ADDR_BITS'(1);

    // Codes 0 and 7 are reserved, so they fall back to the power-up latency.
    always_comb begin
        if (cfg_done_q && (lat_code != 3'd0) && (lat_code != 3'd7)) begin
            lat_m1 = CNT_W'(lat_code) - CNT_W'(1);
        end else begin
            lat_m1 = CNT_W'(DEFAULT_LATENCY - 1);
        end
    end

    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        dir_d      = dir_q;
        wait_d     = wait_q;
        rdata_d    = rdata_q;
        bcr_d      = bcr_q;
        cfg_done_d = cfg_done_q;
        wr_en      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                wait_d = 1'b1;
                if (bus.mem_cre && bus.mem_addr_valid) begin
                    bcr_d   = bus.mem_addr;
                    wait_d  = 1'b0;
                    cnt_d   = CNT_W'(CFG_CYCLES - 1);
                    state_d = S_CFG;
                end else if (!bus.mem_ce && bus.mem_addr_valid) begin
                    addr_d  = bus.mem_addr[ADDR_BITS-1:0];
                    dir_d   = bus.mem_we;
                    wait_d  = 1'b0;
                    cnt_d   = lat_m1;
                    state_d = S_LATENCY;
                end
            end

            S_CFG: begin
                if (cnt_q == '0) begin
                    wait_d     = 1'b1;
                    cfg_done_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_LATENCY: begin
                if (bus.mem_ce) begin
                    wait_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    wait_d = 1'b1;
                    if (dir_q) begin
                        state_d = S_BURST_WR;
                    end else begin
                        rdata_d = mem_q[addr_q];
                        state_d = S_BURST_RD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_BURST_WR: begin
                if (bus.mem_ce) begin
                    wait_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (bus.mem_we) begin
                    wr_en  = 1'b1;
                    addr_d = addr_inc;
                end
            end

            S_BURST_RD: begin
                if (bus.mem_ce) begin
                    wait_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    addr_d  = addr_inc;
                    rdata_d = mem_q[addr_inc];
                end
            end

            default: begin
                wait_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: registers update with <= so every flop samples the pre-edge values together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            dir_q      <= 1'b0;
            wait_q     <= 1'b1;
            rdata_q    <= '0;
            bcr_q      <= '0;
            cfg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            dir_q      <= dir_d;
            wait_q     <= wait_d;
            rdata_q    <= rdata_d;
            bcr_q      <= bcr_d;
            cfg_done_q <= cfg_done_d;
        end
    end

    // NOTE: the word array is deliberately outside the reset so contents survive it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr_q] <= bus.mem_data_in;
        end
    end

    assign bus.mem_data_out = rdata_q;
    assign bus.mem_data_oe  = (state_q == S_BURST_RD) & ~bus.mem_oe & ~bus.mem_ce;
    assign bus.mem_wait     = wait_q;
    assign bcr              = bcr_q;
    assign config_done      = cfg_done_q;
endmodule
